// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types and constants for the DVP camera capture path.
// H/V defaults are also consumed by the HDMI timing generator.
package dvp_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        WAIT_VS,
        ARMED,
        CAPTURE,
        DROP
    } cap_state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// dvp_sync_edge: registers the DVP bus once and derives frame/line edges
// from the registered VSYNC (polarity-normalised) and HREF.
import dvp_pkg::*;

module dvp_sync_edge #(
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_data,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_vs_rise,
    output logic       o_vs_fall,
    output logic       o_href_fall
);

    localparam logic L_VS_IDLE = !VSYNC_POL;

    logic       r_vsync_d1;
    logic       r_vs_act_d2;
    logic       r_href_d1;
    logic       r_href_d2;
    logic [7:0] r_data_d1;
    logic       w_vs_act;

    assign w_vs_act = r_vsync_d1 ^ !VSYNC_POL;

    // The delayed copy resets to the same value the live one has in reset,
    // so leaving reset never fabricates an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vsync_d1  <= 1'b0;
            r_vs_act_d2 <= L_VS_IDLE;
            r_href_d1   <= 1'b0;
            r_href_d2   <= 1'b0;
            r_data_d1   <= 8'h00;
        end else begin
            r_vsync_d1  <= i_vsync;
            r_vs_act_d2 <= w_vs_act;
            r_href_d1   <= i_href;
            r_href_d2   <= r_href_d1;
            r_data_d1   <= i_data;
        end
    end

    assign o_href      = r_href_d1;
    assign o_data      = r_data_d1;
    assign o_vs_rise   = w_vs_act & !r_vs_act_d2;
    assign o_vs_fall   = !w_vs_act & r_vs_act_d2;
    assign o_href_fall = !r_href_d1 & r_href_d2;

endmodule

// File: rtl/dvp_capture_rgb565.sv
// dvp_capture_rgb565: frame-aligned OV5640 DVP capture into RGB565 FIFO words.
// Optional colour-bar source compiled in with DVP_TEST_PATTERN_EN.
import dvp_pkg::*;

module dvp_capture_rgb565 #(
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter bit VSYNC_POL     = 1'b1,
    parameter bit HI_BYTE_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        capture_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_full,
`ifdef DVP_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        fifo_write_en,
    output logic [15:0] fifo_data_out,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        overflow,
    output logic [9:0]  pixel_x,
    output logic [9:0]  line_y,
    output logic [15:0] frame_count
);

    localparam logic [9:0] L_H = 10'(H_ACTIVE);
    localparam logic [9:0] L_V = 10'(V_ACTIVE);

    logic       w_href;
    logic [7:0] w_data;
    logic       w_vs_rise;
    logic       w_vs_fall;
    logic       w_href_fall;

    dvp_sync_edge #(
        .VSYNC_POL (VSYNC_POL)
    ) u_sync (
        .clock       (clock),
        .reset       (reset),
        .i_vsync     (cam_vsync),
        .i_href      (cam_href),
        .i_data      (cam_data),
        .o_href      (w_href),
        .o_data      (w_data),
        .o_vs_rise   (w_vs_rise),
        .o_vs_fall   (w_vs_fall),
        .o_href_fall (w_href_fall)
    );

    cap_state_t  r_state;
    cap_state_t  w_next;
    logic        r_phase;
    logic [7:0]  r_lo;
    logic [9:0]  r_px;
    logic [9:0]  r_ly;
    logic        r_ovf;
    logic        r_line_err;
    logic        r_we;
    logic [15:0] r_data;
    logic        r_done;
    logic        r_ok;
    logic [15:0] r_fc;

    logic        w_cap;
    logic        w_in_win;
    logic        w_ovf_hit;
    logic        w_start;
    logic [9:0]  w_ly_inc;
    logic [9:0]  w_ly_end;
    logic        w_err_end;
    logic        w_ok;
    logic [15:0] w_word;
    logic [15:0] w_word_out;

    assign w_cap     = (r_state == CAPTURE);
    assign w_in_win  = (r_px < L_H) && (r_ly < L_V);
    assign w_ovf_hit = w_cap && w_href && r_phase && w_in_win && fifo_full;
    assign w_start   = (r_state == ARMED) && w_vs_fall && capture_en;
    assign w_ly_inc  = (r_ly == 10'h3FF) ? r_ly : r_ly + 10'd1;

    // A line ending on the same cycle as the frame counts toward the verdict.
    assign w_ly_end  = w_href_fall ? w_ly_inc : r_ly;
    assign w_err_end = r_line_err | (w_href_fall & r_phase);
    assign w_ok      = (w_ly_end == L_V) && !r_ovf && !w_err_end;

    assign w_word = HI_BYTE_FIRST ? {r_lo, w_data} : {w_data, r_lo};

`ifdef DVP_TEST_PATTERN_EN
    localparam logic [9:0] L_BAR_W = 10'(H_ACTIVE / 8);

    logic [9:0] w_bar_q;
    logic [2:0] w_bar_idx;

    assign w_bar_q    = r_px / L_BAR_W;
    assign w_bar_idx  = (w_bar_q > 10'd7) ? 3'd7 : w_bar_q[2:0];
    assign w_word_out = test_mode ? bar_color(w_bar_idx) : w_word;
`else
    assign w_word_out = w_word;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_VS;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_VS: if (w_vs_rise) w_next = ARMED;
            ARMED:   if (w_start) w_next = CAPTURE;
            CAPTURE: begin
                if (w_vs_rise) w_next = ARMED;
                else if (w_ovf_hit) w_next = DROP;
            end
            DROP:    if (w_vs_rise) w_next = ARMED;
            default: w_next = WAIT_VS;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase    <= 1'b0;
            r_lo       <= 8'h00;
            r_px       <= 10'd0;
            r_ly       <= 10'd0;
            r_ovf      <= 1'b0;
            r_line_err <= 1'b0;
            r_we       <= 1'b0;
            r_data     <= 16'h0000;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_fc       <= 16'h0000;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_start) begin
                r_ovf      <= 1'b0;
                r_px       <= 10'd0;
                r_ly       <= 10'd0;
                r_phase    <= 1'b0;
                r_line_err <= 1'b0;
            end
            if (w_cap) begin
                if (w_href) begin
                    r_phase <= !r_phase;
                    if (!r_phase) begin
                        r_lo <= w_data;
                    end else if (w_in_win) begin
                        if (fifo_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_we   <= 1'b1;
                            r_data <= w_word_out;
                            r_px   <= r_px + 10'd1;
                        end
                    end
                end
                if (w_href_fall) begin
                    r_phase <= 1'b0;
                    r_px    <= 10'd0;
                    r_ly    <= w_ly_inc;
                    if (r_phase) r_line_err <= 1'b1;
                end
                if (w_vs_rise) begin
                    r_done <= 1'b1;
                    r_ok   <= w_ok;
                    if (w_ok) r_fc <= r_fc + 16'd1;
                end
            end
            if ((r_state == DROP) && w_vs_rise) begin
                r_done <= 1'b1;
                r_ok   <= 1'b0;
            end
        end
    end

    assign fifo_write_en = r_we;
    assign fifo_data_out = r_data;
    assign frame_done    = r_done;
    assign frame_ok      = r_ok;
    assign overflow      = r_ovf;
    assign pixel_x       = r_px;
    assign line_y        = r_ly;
    assign frame_count   = r_fc;

endmodule

// File: tb/tb_dvp_capture_rgb565.sv
// tb_dvp_capture_rgb565: random DVP frames against a frame-level model;
// two DUTs cover both byte orders and both VSYNC polarities.
`timescale 1ns/1ps
module tb_dvp_capture_rgb565;

    localparam int H = 16;
    localparam int V = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cap_en = 1'b0;
    logic       vs = 1'b0;
    logic       hr = 1'b0;
    logic       full = 1'b0;
    logic [7:0] d = 8'h00;
    logic       vs_n;

    assign vs_n = !vs;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_we, a_done, a_ok, a_ovf;
    logic [15:0] a_data, a_fc;
    logic [9:0]  a_px, a_ly;
    logic        b_we, b_done, b_ok, b_ovf;
    logic [15:0] b_data, b_fc;
    logic [9:0]  b_px, b_ly;

    dvp_capture_rgb565 #(
        .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1'b1), .HI_BYTE_FIRST(1'b1)
    ) u_dut_a (
        .clock(clk), .reset(rst), .capture_en(cap_en),
        .cam_vsync(vs), .cam_href(hr), .cam_data(d), .fifo_full(full),
`ifdef DVP_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .fifo_write_en(a_we), .fifo_data_out(a_data),
        .frame_done(a_done), .frame_ok(a_ok), .overflow(a_ovf),
        .pixel_x(a_px), .line_y(a_ly), .frame_count(a_fc)
    );

    dvp_capture_rgb565 #(
        .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1'b0), .HI_BYTE_FIRST(1'b0)
    ) u_dut_b (
        .clock(clk), .reset(rst), .capture_en(cap_en),
        .cam_vsync(vs_n), .cam_href(hr), .cam_data(d), .fifo_full(full),
`ifdef DVP_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .fifo_write_en(b_we), .fifo_data_out(b_data),
        .frame_done(b_done), .frame_ok(b_ok), .overflow(b_ovf),
        .pixel_x(b_px), .line_y(b_ly), .frame_count(b_fc)
    );

    typedef struct {
        logic [15:0] w;
        int          c;
    } wr_t;

    typedef struct {
        logic        ok;
        logic [15:0] fc;
        logic        ovf;
        int          ly;
    } st_t;

    wr_t qa[$];
    wr_t qb[$];
    st_t sa[$];
    st_t sb[$];
    wr_t ea, eb;
    st_t fa, fb;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_we) begin
                if (qa.size() == 0) chk("wr_a_unexpected", qa.size(), 1);
                else begin
                    ea = qa.pop_front();
                    chk("wr_a_data", a_data, ea.w);
                    chk("wr_a_cycle", cyc, ea.c);
                end
            end
            if (a_done) begin
                chk("done_a_pending_writes", qa.size(), 0);
                if (sa.size() == 0) chk("done_a_unexpected", sa.size(), 1);
                else begin
                    fa = sa.pop_front();
                    chk("ok_a", a_ok, fa.ok);
                    chk("fc_a", a_fc, fa.fc);
                    chk("ovf_a", a_ovf, fa.ovf);
                    if (fa.ly >= 0) chk("ly_a", a_ly, fa.ly);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_we) begin
                if (qb.size() == 0) chk("wr_b_unexpected", qb.size(), 1);
                else begin
                    eb = qb.pop_front();
                    chk("wr_b_data", b_data, eb.w);
                    chk("wr_b_cycle", cyc, eb.c);
                end
            end
            if (b_done) begin
                chk("done_b_pending_writes", qb.size(), 0);
                if (sb.size() == 0) chk("done_b_unexpected", sb.size(), 1);
                else begin
                    fb = sb.pop_front();
                    chk("ok_b", b_ok, fb.ok);
                    chk("fc_b", b_fc, fb.fc);
                    chk("ovf_b", b_ovf, fb.ovf);
                    if (fb.ly >= 0) chk("ly_b", b_ly, fb.ly);
                end
            end
        end
    end

    // Frame-level reference: a frame is captured only if the block was armed
    // by a previous frame end and capture_en was high at its start.
    bit          armed = 1'b0;
    logic [15:0] fc_m = 16'd0;

    task automatic chk_reset_vals();
        chk("rst_we_a", a_we, 0);
        chk("rst_data_a", a_data, 0);
        chk("rst_done_a", a_done, 0);
        chk("rst_ok_a", a_ok, 0);
        chk("rst_ovf_a", a_ovf, 0);
        chk("rst_px_a", a_px, 0);
        chk("rst_ly_a", a_ly, 0);
        chk("rst_fc_a", a_fc, 0);
        chk("rst_fc_b", b_fc, 0);
        chk("rst_ly_b", b_ly, 0);
    endtask

    task automatic end_frame(input bit cap, input int nl, input bit dropped, input bit lerr);
        st_t s;
        if (cap) begin
            s.ok  = (nl == V) && !dropped && !lerr;
            if (s.ok) fc_m = fc_m + 16'd1;
            s.fc  = fc_m;
            s.ovf = dropped;
            s.ly  = dropped ? -1 : nl;
            sa.push_back(s);
            sb.push_back(s);
        end
        vs = 1'b1;
    endtask

    task automatic frame(input int nl, input int nb, input int odd_ln,
                         input int full_ln, input int full_px, input int rst_ln,
                         input bit en, input bit mid_en, input bit sim_end);
        bit         cap;
        bit         dropped;
        bit         lerr;
        bit         ended;
        logic [7:0] b0;
        dropped = 1'b0;
        lerr    = 1'b0;
        ended   = 1'b0;
        b0      = 8'h00;
        cap_en  = en;
        repeat (4) @(negedge clk);
        vs  = 1'b0;
        cap = armed && en;
        repeat (3) @(negedge clk);
        cap_en = mid_en;
        for (int l = 0; l < nl; l++) begin
            int n;
            n = (l == odd_ln) ? nb + 1 : nb;
            if (cap && (n % 2 == 1)) lerr = 1'b1;
            for (int i = 0; i < n; i++) begin
                d  = 8'($urandom);
                hr = 1'b1;
                if (i % 2 == 0) b0 = d;
                else begin
                    if (cap && !dropped && l < V && i / 2 < H) begin
                        if (l == full_ln && i / 2 == full_px) begin
                            full    = 1'b1;
                            dropped = 1'b1;
                        end else begin
                            qa.push_back('{w: {b0, d}, c: cyc + 2});
                            qb.push_back('{w: {d, b0}, c: cyc + 2});
                        end
                    end
                end
                @(negedge clk);
            end
            hr = 1'b0;
            if (sim_end && l == nl - 1) begin
                end_frame(cap, nl, dropped, lerr);
                ended = 1'b1;
            end
            repeat (4) @(negedge clk);
            if (l == rst_ln) begin
                rst = 1'b1;
                #1;
                chk_reset_vals();
                @(negedge clk);
                rst   = 1'b0;
                cap   = 1'b0;
                armed = 1'b0;
                fc_m  = 16'd0;
            end
        end
        if (!ended) end_frame(cap, nl, dropped, lerr);
        repeat (3) @(negedge clk);
        full  = 1'b0;
        armed = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        frame(V, 2*H, -1, -1, -1, -1, 1'b1, 1'b1, 1'b0);
        frame(V, 2*H, -1, -1, -1, -1, 1'b1, 1'b1, 1'b0);
        frame(V, 2*H, -1, 2, 5, -1, 1'b1, 1'b1, 1'b0);
        frame(V, 2*H, -1, -1, -1, -1, 1'b1, 1'b1, 1'b1);
        frame(V + 3, 2*H + 4, -1, -1, -1, -1, 1'b1, 1'b1, 1'b0);
        frame(V, 2*H, 1, -1, -1, -1, 1'b1, 1'b1, 1'b0);
        frame(V, 2*H, -1, -1, -1, -1, 1'b0, 1'b1, 1'b0);
        frame(V, 2*H, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
        frame(V, 2*H, -1, -1, -1, -1, 1'b0, 1'b1, 1'b0);
        frame(V, 2*H, -1, -1, -1, -1, 1'b1, 1'b1, 1'b0);
        frame(V, 2*H, -1, -1, -1, 2, 1'b1, 1'b1, 1'b0);
        frame(V, 2*H, -1, -1, -1, -1, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int nl, nb, fl, fp;
            nl = $urandom_range(V + 1, V - 1);
            nb = $urandom_range(2*H + 3, 2*H - 3);
            fl = ($urandom_range(3, 0) == 0) ? $urandom_range(V - 1, 0) : -1;
            fp = $urandom_range(H - 1, 0);
            frame(nl, nb, -1, fl, fp, -1,
                  ($urandom_range(4, 0) != 0), 1'($urandom),
                  1'($urandom));
        end

        repeat (20) @(negedge clk);
        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);
        chk("end_sa_empty", sa.size(), 0);
        chk("end_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
